// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scan controller: debounce, row scan, key FIFO, bus registers and IRQ.
// Define KEY_REPEAT_EN to re-push a held single key every REPEAT_CYCLES.
module keypad_scan_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned SCAN_SETTLE     = 2,
  parameter int unsigned FIFO_DEPTH      = 4
`ifdef KEY_REPEAT_EN
  ,
  parameter int unsigned REPEAT_CYCLES   = 25000
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  column,
  output logic [3:0]  row,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [2:0]  address,
  input  logic [15:0] write_data,
  output logic [15:0] read_data_output,
  output logic        interrupt
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned ST_W   = $clog2(SCAN_SETTLE + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned CODE_W = 12;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(SCAN_SETTLE);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
`ifdef KEY_REPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {IDLE, DEBOUNCE, SCAN, RELEASE} state_t;

  state_t            state_q, state_d;
  logic [DB_W-1:0]   db_q, db_d;
  logic [ST_W-1:0]   st_q, st_d;
  logic [1:0]        r_q, r_d;
  logic [3:0]        row_q, row_d;
  logic              push_c;
  logic [CODE_W-1:0] push_code_c;
`ifdef KEY_REPEAT_EN
  logic [CODE_W-1:0] cap_q, cap_d;
  logic              hold_q, hold_d;
  logic [RPT_W-1:0]  rpt_q, rpt_d;
`endif

  logic              enable_q, irq_en_q, re_q, ovf_q;
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [CNT_W-1:0]  count_q;
  logic [CODE_W-1:0] mem_q [FIFO_DEPTH];

  logic       col_idle_c, single_c;
  logic [1:0] col_idx_c;
  logic [3:0] key_c;
  logic       pop_c, flush_c, ovf_clr_c, ctrl_wr_c, full_c, not_empty_c, push_ok_c;
  logic       unused_wdata;

  assign unused_wdata = ^write_data[15:3];

  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0:    k = 4'h1;
      4'h1:    k = 4'h4;
      4'h2:    k = 4'h7;
      4'h3:    k = 4'hE;
      4'h4:    k = 4'h2;
      4'h5:    k = 4'h5;
      4'h6:    k = 4'h8;
      4'h7:    k = 4'h0;
      4'h8:    k = 4'h3;
      4'h9:    k = 4'h6;
      4'hA:    k = 4'h9;
      4'hB:    k = 4'hF;
      4'hC:    k = 4'hA;
      4'hD:    k = 4'hB;
      4'hE:    k = 4'hC;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  // Column decode: which single line is low, if exactly one.
  always_comb begin
    col_idx_c = 2'd0;
    single_c  = 1'b1;
    case (column)
      4'b1110: col_idx_c = 2'd0;
      4'b1101: col_idx_c = 2'd1;
      4'b1011: col_idx_c = 2'd2;
      4'b0111: col_idx_c = 2'd3;
      default: single_c  = 1'b0;
    endcase
  end

  assign col_idle_c = (column == 4'b1111);
  assign key_c      = key_lookup(r_q, col_idx_c);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      db_q    <= '0;
      st_q    <= '0;
      r_q     <= '0;
      row_q   <= '0;
`ifdef KEY_REPEAT_EN
      cap_q   <= '0;
      hold_q  <= 1'b0;
      rpt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      db_q    <= db_d;
      st_q    <= st_d;
      r_q     <= r_d;
      row_q   <= row_d;
`ifdef KEY_REPEAT_EN
      cap_q   <= cap_d;
      hold_q  <= hold_d;
      rpt_q   <= rpt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    db_d        = db_q;
    st_d        = st_q;
    r_d         = r_q;
    row_d       = row_q;
    push_c      = 1'b0;
    push_code_c = {key_c, column, row_q};
`ifdef KEY_REPEAT_EN
    cap_d       = cap_q;
    hold_d      = hold_q;
    rpt_d       = rpt_q;
`endif
    unique case (state_q)
      IDLE: begin
        row_d = 4'b0000;
        if (!col_idle_c) begin
          db_d    = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (col_idle_c) begin
          state_d = IDLE;
        end else if (db_q == DB_LAST) begin
          state_d = SCAN;
          row_d   = 4'b1110;
          r_d     = 2'd0;
          st_d    = '0;
        end else begin
          db_d = db_q + DB_W'(1);
        end
      end
      SCAN: begin
        if (st_q != ST_LAST) begin
          st_d = st_q + ST_W'(1);
        end else if (col_idle_c) begin
          if (r_q == 2'd3) begin
            state_d = IDLE;
            row_d   = 4'b0000;
          end else begin
            r_d   = r_q + 2'd1;
            row_d = ~(4'b0001 << (r_q + 2'd1));
            st_d  = '0;
          end
        end else begin
          // Multi-key (ghost) presses still wait out the release, just without a push.
          push_c  = single_c;
          state_d = RELEASE;
          row_d   = 4'b0000;
          db_d    = '0;
`ifdef KEY_REPEAT_EN
          cap_d   = push_code_c;
          hold_d  = single_c;
          rpt_d   = '0;
          if (single_c) row_d = row_q;
`endif
        end
      end
      RELEASE: begin
`ifdef KEY_REPEAT_EN
        // Keep the captured row driven so the held key remains visible for repeat.
        row_d = hold_q ? cap_q[3:0] : 4'b0000;
        if (hold_q && (column == cap_q[7:4])) begin
          if (rpt_q == RPT_LAST) begin
            push_c      = 1'b1;
            push_code_c = cap_q;
            rpt_d       = '0;
          end else begin
            rpt_d = rpt_q + RPT_W'(1);
          end
        end else begin
          rpt_d = '0;
        end
`else
        row_d = 4'b0000;
`endif
        if (col_idle_c) begin
          if (db_q == DB_LAST) begin
            state_d = IDLE;
            row_d   = 4'b0000;
          end else begin
            db_d = db_q + DB_W'(1);
          end
        end else begin
          db_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!enable_q) begin
      state_d = IDLE;
      row_d   = 4'b0000;
      push_c  = 1'b0;
    end
  end

  assign pop_c       = read_enable && !re_q && (address == 3'b000) && not_empty_c;
  assign ctrl_wr_c   = write_enable && (address == 3'b100);
  assign flush_c     = ctrl_wr_c && write_data[2];
  assign ovf_clr_c   = write_enable && (address == 3'b010) && write_data[2];
  assign full_c      = (count_q == CNT_FULL);
  assign not_empty_c = (count_q != '0);
  assign push_ok_c   = push_c && (!full_c || pop_c);

  // Control registers and read-strobe edge detect.
  always_ff @(posedge clock) begin
    if (!reset) begin
      enable_q <= 1'b1;
      irq_en_q <= 1'b1;
      re_q     <= 1'b0;
    end else begin
      re_q <= read_enable;
      if (ctrl_wr_c) begin
        enable_q <= write_data[0];
        irq_en_q <= write_data[1];
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow; flush overrides push and pop.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (flush_c) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok_c) wr_q <= wr_q + PTR_W'(1);
      if (pop_c)     rd_q <= rd_q + PTR_W'(1);
      case ({push_ok_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (push_c && !push_ok_c) ovf_q <= 1'b1;
      else if (ovf_clr_c)       ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && push_ok_c && !flush_c) mem_q[wr_q] <= push_code_c;
  end

  always_comb begin
    read_data_output = 16'd0;
    if (read_enable) begin
      case (address)
        3'b000:  read_data_output = not_empty_c ? {4'd0, mem_q[rd_q]} : 16'd0;
        3'b010:  read_data_output = {13'd0, ovf_q, full_c, not_empty_c};
        3'b100:  read_data_output = {14'd0, irq_en_q, enable_q};
        default: read_data_output = 16'd0;
      endcase
    end
  end

  assign row       = row_q;
  assign interrupt = irq_en_q && not_empty_c;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural 4x4 key matrix model.
module tb_keypad_scan_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  column;
  logic [3:0]  row;
  logic        read_enable = 1'b0;
  logic        write_enable = 1'b0;
  logic [2:0]  address = 3'd0;
  logic [15:0] write_data = 16'd0;
  logic [15:0] read_data_output;
  logic        interrupt;
  logic [15:0] keys = 16'd0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [15:0] mask;
    int          hold;
    logic [15:0] exp_status;
    logic [15:0] exp_key;
  } press_vec_t;

  press_vec_t vecs [8];

  keypad_scan_ctrl #(
    .DEBOUNCE_CYCLES(8),
    .SCAN_SETTLE(1),
    .FIFO_DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .column(column),
    .row(row),
    .read_enable(read_enable),
    .write_enable(write_enable),
    .address(address),
    .write_data(write_data),
    .read_data_output(read_data_output),
    .interrupt(interrupt)
  );

  always #5 clock = ~clock;

  // Key (r,c) = keys[r*4+c]; a pressed key pulls its column low when its row is driven low.
  always_comb begin
    column = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row[r]) column[c] = 1'b0;
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clock);
    address     = a;
    read_enable = 1'b1;
    #1 d = read_data_output;
    @(negedge clock);
    read_enable = 1'b0;
    address     = 3'd0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clock);
    address      = a;
    write_data   = d;
    write_enable = 1'b1;
    @(negedge clock);
    write_enable = 1'b0;
    write_data   = 16'd0;
    address      = 3'd0;
  endtask

  task automatic expect_reg(input string name, input logic [2:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic press(input logic [15:0] m, input int hold);
    @(negedge clock);
    keys = m;
    repeat (hold) @(negedge clock);
    keys = 16'd0;
    repeat (20) @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    vecs[0] = '{"key5_r1c1",    16'h0020, 40, 16'h0001, 16'h05DD};
    vecs[1] = '{"glitch4",      16'h0001,  4, 16'h0000, 16'h0000};
    vecs[2] = '{"glitch6",      16'h0010,  6, 16'h0000, 16'h0000};
    vecs[3] = '{"ghost_r0_1100",16'h0003, 40, 16'h0000, 16'h0000};
    vecs[4] = '{"keyA_r3c0",    16'h1000, 40, 16'h0001, 16'h0AE7};
    vecs[5] = '{"keyE_r0c3",    16'h0008, 40, 16'h0001, 16'h0E7E};
    vecs[6] = '{"key9_r2c2",    16'h0400, 40, 16'h0001, 16'h09BB};
    vecs[7] = '{"key0_r1c3",    16'h0080, 40, 16'h0001, 16'h007D};

    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    check("reset_row", {12'd0, row}, 16'h0000);
    check("reset_irq", {15'd0, interrupt}, 16'h0000);
    check("reset_idle_rdata", read_data_output, 16'h0000);
    expect_reg("reset_status", 3'b010, 16'h0000);
    expect_reg("reset_ctrl", 3'b100, 16'h0003);

    // Table: press, check status and IRQ, pop once, then confirm the FIFO drained.
    for (int i = 0; i < 8; i++) begin
      logic [15:0] d;
      press(vecs[i].mask, vecs[i].hold);
      expect_reg({vecs[i].name, "_status"}, 3'b010, vecs[i].exp_status);
      check({vecs[i].name, "_irq"}, {15'd0, interrupt}, {15'd0, vecs[i].exp_status[0]});
      bus_read(3'b000, d);
      check({vecs[i].name, "_key"}, d, vecs[i].exp_key);
      bus_read(3'b000, d);
      check({vecs[i].name, "_key2"}, d, 16'h0000);
      check({vecs[i].name, "_irq2"}, {15'd0, interrupt}, 16'h0000);
    end

    // Row must be released while a captured key is still held.
    @(negedge clock);
    keys = 16'h0800;
    repeat (30) @(negedge clock);
    check("row_in_release", {12'd0, row}, 16'h0000);
    keys = 16'd0;
    repeat (20) @(negedge clock);
    expect_reg("keyF_key", 3'b000, 16'h0F7B);

    // Ghost press followed by a short release: a new key during RELEASE is never captured.
    @(negedge clock);
    keys = 16'h0003;
    repeat (40) @(negedge clock);
    keys = 16'd0;
    repeat (4) @(negedge clock);
    keys = 16'h0020;
    repeat (40) @(negedge clock);
    keys = 16'd0;
    repeat (20) @(negedge clock);
    expect_reg("ghost_release_wait_status", 3'b010, 16'h0000);

    // Five presses without reads: overflow, then in-order drain.
    press(16'h0001, 40);
    press(16'h0010, 40);
    press(16'h0100, 40);
    press(16'h0002, 40);
    press(16'h0020, 40);
    expect_reg("ovf_status", 3'b010, 16'h0007);
    check("ovf_irq", {15'd0, interrupt}, 16'h0001);
    expect_reg("ovf_key0", 3'b000, 16'h01EE);
    expect_reg("ovf_key1", 3'b000, 16'h02ED);
    expect_reg("ovf_key2", 3'b000, 16'h03EB);
    expect_reg("ovf_key3", 3'b000, 16'h04DE);
    expect_reg("ovf_drained_status", 3'b010, 16'h0004);
    bus_write(3'b010, 16'h0004);
    expect_reg("ovf_cleared_status", 3'b010, 16'h0000);

    // Flush through the control register.
    press(16'h0001, 40);
    press(16'h0020, 40);
    expect_reg("pre_flush_status", 3'b010, 16'h0001);
    bus_write(3'b100, 16'h0007);
    expect_reg("flush_status", 3'b010, 16'h0000);
    expect_reg("flush_ctrl", 3'b100, 16'h0003);
    check("flush_irq", {15'd0, interrupt}, 16'h0000);

    // Scanning disabled: presses are ignored.
    bus_write(3'b100, 16'h0002);
    expect_reg("disable_ctrl", 3'b100, 16'h0002);
    press(16'h0020, 40);
    expect_reg("disable_status", 3'b010, 16'h0000);
    bus_write(3'b100, 16'h0003);

    // IRQ masked: key pending but no interrupt.
    bus_write(3'b100, 16'h0001);
    expect_reg("irqmask_ctrl", 3'b100, 16'h0001);
    press(16'h1000, 40);
    expect_reg("irqmask_status", 3'b010, 16'h0001);
    check("irqmask_irq", {15'd0, interrupt}, 16'h0000);
    expect_reg("irqmask_key", 3'b000, 16'h0AE7);
    bus_write(3'b100, 16'h0003);

    // Reset mid-scan clears the FIFO and pushes nothing.
    press(16'h0001, 40);
    @(negedge clock);
    keys = 16'h1000;
    repeat (12) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    keys  = 16'd0;
    reset = 1'b1;
    repeat (20) @(negedge clock);
    expect_reg("midscan_reset_status", 3'b010, 16'h0000);
    expect_reg("midscan_reset_ctrl", 3'b100, 16'h0003);
    check("midscan_reset_row", {12'd0, row}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
